// File: rtl/line_fifo_ctrl_pkg.sv
// line_fifo_ctrl_pkg: shared defaults, pointer width helper and staging depth for the line FIFO
package line_fifo_ctrl_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 24;
  localparam int STG = 2;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/line_fifo_ctrl_if.sv
// line_fifo_ctrl_if: producer/consumer handshake bundle for the line FIFO
interface line_fifo_ctrl_if import line_fifo_ctrl_pkg::*; #(parameter int AW = AW_DEF, parameter int DW = DW_DEF);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  modport master(output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, level);
  modport slave(input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, level);
endinterface

// File: rtl/line_fifo_ctrl_ram.sv
// Dul_Ram: simple dual-port RAM, port A write, port B registered read with one-cycle latency
module Dul_Ram #(parameter int L = 8, parameter int DW = 24) (
  input  logic          ac,
  input  logic          aw,
  input  logic [L-1:0]  aa,
  input  logic [DW-1:0] ad,
  input  logic          bc,
  input  logic          br,
  input  logic [L-1:0]  ba,
  output logic [DW-1:0] bd
);
  logic [DW-1:0] mem [2**L];
  always_ff @(posedge ac)
    if (aw) mem[aa] <= ad;
  always_ff @(posedge bc)
    if (br) bd <= mem[ba];
endmodule

// File: rtl/line_fifo_ctrl.sv
// line_fifo_ctrl: FWFT FIFO sequencer over a dual-port RAM with two staging registers hiding read latency
module line_fifo_ctrl import line_fifo_ctrl_pkg::*; #(parameter int AW = AW_DEF, parameter int DW = DW_DEF) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  line_fifo_ctrl_if.slave bus
);
  localparam int PW = ptr_w(AW);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, ram_cnt;
  logic pend_q, pend_d, ov_q, ov_d, sv_q, sv_d;
  logic [DW-1:0] out_q, out_d, skid_q, skid_d, rd_data;
  logic push, pop, issue, ov1, mv, ov2, sv2;
  logic [1:0] occ;
  Dul_Ram #(.L(AW), .DW(DW)) u_ram (
    .ac(clk), .aw(push), .aa(wptr_q[AW-1:0]), .ad(bus.s_data),
    .bc(clk), .br(issue), .ba(rptr_q[AW-1:0]), .bd(rd_data)
  );
  always_comb begin
    ram_cnt = wptr_q - rptr_q;
    bus.s_ready = rst_n && !clr && ram_cnt != PW'(2**AW);
    push = bus.s_valid && bus.s_ready;
    pop = ov_q && bus.m_ready;
    occ = 2'(ov_q) + 2'(sv_q) + 2'(pend_q) - 2'(pop);
    issue = !clr && ram_cnt != '0 && occ < 2'(STG);
    ov1 = ov_q && !pop;
    mv = !ov1 && sv_q;
    ov2 = ov1 || sv_q;
    sv2 = sv_q && ov1;
    out_d = mv ? skid_q : (pend_q && !ov2) ? rd_data : out_q;
    skid_d = (pend_q && ov2) ? rd_data : skid_q;
    ov_d = !clr && (ov2 || pend_q);
    sv_d = !clr && (sv2 || (pend_q && ov2));
    pend_d = issue;
    wptr_d = clr ? '0 : wptr_q + PW'(push);
    rptr_d = clr ? '0 : rptr_q + PW'(issue);
    bus.m_valid = ov_q;
    bus.m_data = out_q;
    bus.level = (AW+2)'(ram_cnt) + (AW+2)'(pend_q) + (AW+2)'(ov_q) + (AW+2)'(sv_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      pend_q <= 1'b0;
      ov_q <= 1'b0;
      sv_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pend_q <= pend_d;
      ov_q <= ov_d;
      sv_q <= sv_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
endmodule
